// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry-select adder: default geometry,
// stage-count helper and the per-stage payload layout.
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  // Guarded so a bad SEG reaches the top-level elaboration check instead of a divide-by-zero.
  function automatic int num_stages(input int width, input int seg);
    return (seg < 1) ? 1 : width / seg;
  endfunction

  // Payload at the default width; the top re-declares the same layout at its own WIDTH.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic                 ovf;
    logic [DEF_WIDTH-1:0] sum;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } stage_t;

endpackage

// File: rtl/csa_segment.sv
// One carry-select segment: both carry hypotheses summed in parallel, then
// selected by the incoming carry.
module csa_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG:0] sum0;
  logic [SEG:0] sum1;
  logic [SEG:0] sel;

  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};
  assign sel  = cin ? sum1 : sum0;

  assign sum  = sel[SEG-1:0];
  assign cout = sel[SEG];
  // Carry into the MSB recovered from the MSB sum bit and its operands.
  assign cmsb = sel[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipelined_csa_adder.sv
// Streaming WIDTH-bit adder resolving one SEG-bit carry-select segment per
// stage, with a single global stall driven by the output handshake.
module pipelined_csa_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_OUT,
  output logic             OVF
);

  localparam int N = num_stages(WIDTH, SEG);

  if (SEG < 1) begin : g_bad_seg
    $error("pipelined_csa_adder: SEG must be at least 1");
  end else if (WIDTH % SEG != 0) begin : g_bad_width
    $error("pipelined_csa_adder: WIDTH must be a multiple of SEG");
  end

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pipe_t;

  pipe_t src [N];
  pipe_t nxt [N];
  pipe_t st  [N];
  logic  adv;

  assign adv      = !st[N-1].valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic [SEG-1:0] seg_sum;
    logic           seg_cout;
    logic           seg_cmsb;
    pipe_t          upd;

    if (k == 0) begin : g_head
      assign src[k] = '{valid: in_valid, carry: C_IN, ovf: 1'b0,
                        sum: '0, a: A, b: B};
    end else begin : g_body
      assign src[k] = st[k-1];
    end

    csa_segment #(.SEG(SEG)) u_seg (
      .a    (src[k].a[k*SEG +: SEG]),
      .b    (src[k].b[k*SEG +: SEG]),
      .cin  (src[k].carry),
      .sum  (seg_sum),
      .cout (seg_cout),
      .cmsb (seg_cmsb)
    );

    // Every stage records its would-be overflow; only the last one is exposed.
    always_comb begin
      upd                   = src[k];
      upd.sum[k*SEG +: SEG] = seg_sum;
      upd.carry             = seg_cout;
      upd.ovf               = seg_cmsb ^ seg_cout;
    end

    assign nxt[k] = upd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) st[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < N - 1; k++) st[k] <= nxt[k];
      // The last stage keeps its result fields across bubbles.
      if (nxt[N-1].valid) st[N-1] <= nxt[N-1];
      else                st[N-1].valid <= 1'b0;
    end
  end

  assign out_valid = st[N-1].valid;
  assign S         = st[N-1].sum;
  assign C_OUT     = st[N-1].carry;
  assign OVF       = st[N-1].ovf;

endmodule

// File: doc/pipelined_csa_adder.md
# pipelined_csa_adder

Parametrised, pipelined carry-select adder with valid/ready handshakes on both sides. It computes `{C_OUT, S} = A + B + C_IN` over `WIDTH` bits, one `SEG`-bit segment per pipeline stage, and also reports signed overflow. It accepts one operation per cycle and is the streaming successor to the team's fixed 4-bit combinational adder, sitting between operand sources and result consumers in the datapath.

## Interface
- `WIDTH`, default 16: operand and sum width; must be a multiple of `SEG`.
- `SEG`, default 4: segment width, i.e. bits resolved per stage. The stage count is `N = WIDTH/SEG`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  `A`, `B` and `C_IN` are presented.
- `in_ready`  out  1  adder can accept this cycle.
- `A`  in  `WIDTH`  operand A.
- `B`  in  `WIDTH`  operand B.
- `C_IN`  in  1  carry in.
- `out_valid`  out  1  `S`, `C_OUT` and `OVF` hold a result.
- `out_ready`  in  1  consumer accepts the result.
- `S`  out  `WIDTH`  sum.
- `C_OUT`  out  1  carry out of the MSB.
- `OVF`  out  1  two's-complement overflow, computed as carry into the MSB XOR `C_OUT`.

## Operation
- **Transfers.** An input transfer occurs on a cycle where `in_valid && in_ready`. An output transfer occurs on a cycle where `out_valid && out_ready`.
- **Stages.** The pipeline has `N` stages. Each stage register holds:
  - a valid bit;
  - the carry into the next segment;
  - the sum bits resolved so far;
  - the unprocessed upper operand bits.
- **Per-stage work.** Stage k computes segment k, bits `[k*SEG +: SEG]`, twice: once with carry 0 and once with carry 1. The registered carry from stage k-1 selects between them; stage 0 uses `C_IN`. The selected sum and carry-out are registered.
- **Last stage.** Stage N-1 also registers `OVF`, derived from the carry into bit `WIDTH-1` and the segment carry-out.
- **Stall rule.**
  - Global advance is `adv = !out_valid || out_ready`, and `in_ready = adv`.
  - When `adv` is 0, every stage register (data and valid) holds.
  - When `adv` is 1, every stage shifts forward. Stage 0 loads the input on an input transfer; otherwise it loads a bubble with valid 0.
- **Outputs.** `out_valid` is the stage N-1 valid bit. `S`, `C_OUT` and `OVF` come directly from the stage N-1 registers and are stable while `out_valid && !out_ready`.
- **Bubbles.** Data in an invalid stage is don't-care for compute, but the output registers update only on valid data. When the last stage loads a bubble, `S`, `C_OUT` and `OVF` keep their previous values.
- **Width rules.** Arithmetic is unsigned modulo 2^WIDTH, with the carry in `C_OUT`. `OVF` is meaningful only under a signed interpretation and is always produced.
- **Elaboration checks.** Elaboration must fail if `WIDTH % SEG != 0` or `SEG < 1`.
- **Degenerate case.** `SEG == WIDTH` gives a single stage with latency 1.

## Timing
- **Reset values** (while `rst_n` = 0): all valid bits 0, `out_valid`=0, `in_ready`=1, `S`=0, `C_OUT`=0, `OVF`=0.
- **Reset mid-operation.** In-flight operations are discarded with no partial output. The first accept after `rst_n` rises behaves as from an empty pipeline.
- **Latency.** An input accepted at edge t produces `out_valid` from edge t+N, provided no stall occurs. Each cycle of `adv`=0 adds one cycle.
- **Throughput.** One operation per cycle when `out_ready` is held at 1.
- **Full pipeline.** With `out_valid`=1 and `out_ready`=0, `in_ready`=0 combinationally in the same cycle.
- **Simultaneous events.** An output transfer and an input transfer in the same cycle are legal; the pipeline shifts by one.
- **Ordering.** Results leave strictly in acceptance order; none are dropped or duplicated.
- **Combinational paths.** The only combinational path is `out_ready` → `in_ready`. There is no path from `in_valid` to any output.

## Structure
- **Shared package `adder_pkg`:**
  - `WIDTH`/`SEG` defaults;
  - function `num_stages(WIDTH, SEG)`;
  - the per-stage payload struct: valid, carry, partial sum, remaining A/B.
- **Sub-module `csa_segment`** (combinational, parameter `SEG`):
  - inputs `a`, `b`, `cin`;
  - outputs `sum` and `cout`, with the carry-0 and carry-1 sums computed in parallel and muxed by `cin`;
  - also outputs the carry into the segment MSB, used for `OVF`.
- **Top level:** instantiates `N` copies of `csa_segment` in a generate loop, plus the stage registers and the stall logic.

## Test plan
All scenarios use WIDTH=16, SEG=4 (N=4) unless stated.
- **Carry out:** `A`=0xFFFF, `B`=0x0001, `C_IN`=0 → 4 cycles later `S`=0x0000, `C_OUT`=1, `OVF`=0.
- **Signed overflow:** `A`=0x7FFF, `B`=0x0001, `C_IN`=0 → `S`=0x8000, `C_OUT`=0, `OVF`=1. Also `A`=0x8000, `B`=0x8000, `C_IN`=1 → `S`=0x0001, `C_OUT`=1, `OVF`=1.
- **Streaming:** 100 back-to-back random operations with `out_ready`=1 → one result per cycle after a 4-cycle fill, in order, each matching the `A+B+C_IN` model.
- **Backpressure:** hold `out_ready`=0 for 5 cycles while `in_valid`=1 → `in_ready`=0 in those cycles, `S` stable, no loss or duplication after release.
- **Reset mid-flight:** assert `rst_n`=0 with 3 operations in flight → all outputs go to their reset values asynchronously. After release, the first new operation appears exactly 4 cycles after acceptance and no stale results appear.
- **Parameter sweep:** exhaustive over WIDTH=4 with SEG=4, 2 and 1 (512 vectors each) → `{C_OUT,S}` equals `A+B+C_IN` in every case, with latencies of 1, 2 and 4 respectively.
